// File: rtl/alu2_sequencer_pkg.sv
// Shared types and constants for the multi-cycle ALU sequencer.
package alu2_sequencer_pkg;

    localparam int XLEN         = 32;
    localparam int REG_ADDR_W   = 5;
    localparam int ALU2_TIMEOUT = 64;

    typedef enum logic [4:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_SRA,
        ALU_OR, ALU_AND, ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU,
        ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU
    } alu_commands_t;

    typedef enum logic [1:0] {IDLE, START, WAIT, HOLD} alu2_seq_state_t;

    typedef enum logic [1:0] {UNIT_NONE, UNIT_MUL, UNIT_DIV, UNIT_SHIFT} alu2_unit_t;

endpackage

// File: rtl/alu2_sequencer_if.sv
// Issue and commit handshake between issuer, sequencer and commit stage.
interface alu2_sequencer_if
    import alu2_sequencer_pkg::*;
();
    logic                  issue_valid;
    alu_commands_t         cmd;
    logic [XLEN-1:0]       arg0;
    logic [XLEN-1:0]       arg1;
    logic [REG_ADDR_W-1:0] i_rd;
    logic                  busy;
    logic                  i_error;
    logic                  flush;
    logic [XLEN-1:0]       res;
    logic [REG_ADDR_W-1:0] o_rd;
    logic                  valid;
    logic                  req;
    logic                  o_error;
    logic                  clear;

    modport master (
        output issue_valid, cmd, arg0, arg1, i_rd, flush, clear,
        input  busy, i_error, res, o_rd, valid, req, o_error
    );

    modport slave (
        input  issue_valid, cmd, arg0, arg1, i_rd, flush, clear,
        output busy, i_error, res, o_rd, valid, req, o_error
    );
endinterface

// File: rtl/alu2_cmd_decode.sv
// Maps an ALU command to its execution unit and result-selection flags.
module alu2_cmd_decode
    import alu2_sequencer_pkg::*;
(
    input  alu_commands_t cmd,
    output alu2_unit_t    unit,
    output logic          legal,
    output logic          sel_high,
    output logic          sel_rem,
    output logic          is_signed
);
    always_comb begin
        unit      = UNIT_NONE;
        legal     = 1'b0;
        sel_high  = 1'b0;
        sel_rem   = 1'b0;
        is_signed = 1'b0;
        case (cmd)
            ALU_MUL: begin
                unit  = UNIT_MUL;
                legal = 1'b1;
            end
            ALU_MULH, ALU_MULHSU, ALU_MULHU: begin
                unit     = UNIT_MUL;
                legal    = 1'b1;
                sel_high = 1'b1;
            end
            ALU_DIV: begin
                unit      = UNIT_DIV;
                legal     = 1'b1;
                is_signed = 1'b1;
            end
            ALU_DIVU: begin
                unit  = UNIT_DIV;
                legal = 1'b1;
            end
            ALU_REM: begin
                unit      = UNIT_DIV;
                legal     = 1'b1;
                sel_rem   = 1'b1;
                is_signed = 1'b1;
            end
            ALU_REMU: begin
                unit    = UNIT_DIV;
                legal   = 1'b1;
                sel_rem = 1'b1;
            end
            ALU_SLL, ALU_SRL, ALU_SRA: begin
                unit  = UNIT_SHIFT;
                legal = 1'b1;
            end
            default: ;
        endcase
    end
endmodule

// File: rtl/alu2_sequencer.sv
// Control FSM for the multi-cycle ALU: issue, start unit, wait for done,
// select and correct the result, hold it until the commit stage clears it.
module alu2_sequencer
    import alu2_sequencer_pkg::*;
#(
    parameter int TIMEOUT = ALU2_TIMEOUT
) (
    input  logic                  clk,
    input  logic                  rst_n,
    alu2_sequencer_if.slave       bus,
    output logic [XLEN-1:0]       op_a,
    output logic [XLEN-1:0]       op_b,
    output alu_commands_t         cmd_q,
    output logic                  mul_start,
    output logic                  div_start,
    output logic                  shift_start,
    input  logic                  mul_done,
    input  logic                  div_done,
    input  logic                  shift_done,
    input  logic [XLEN-1:0]       mul_low,
    input  logic [XLEN-1:0]       mul_high,
    input  logic [XLEN-1:0]       div_quotient,
    input  logic [XLEN-1:0]       div_remainder,
    input  logic [XLEN-1:0]       shift_result,
    input  logic                  div_by_zero
);
    localparam int WD_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

    alu2_seq_state_t       state_reg, state_next;
    logic [XLEN-1:0]       op_a_reg, op_a_next, op_b_reg, op_b_next;
    alu_commands_t         cmd_q_reg, cmd_q_next;
    logic [REG_ADDR_W-1:0] rd_reg, rd_next;
    logic [XLEN-1:0]       res_reg, res_next;
    logic                  err_reg, err_next, valid_reg, valid_next;
    logic                  ierr_reg, ierr_next;
    logic [2:0]            start_reg, start_next;   // {shift, div, mul}
    logic [WD_W-1:0]       wd_reg, wd_next;
    alu2_unit_t            unit_reg, unit_next;
    logic                  high_reg, high_next, rem_reg, rem_next, sgn_reg, sgn_next;

    alu2_unit_t dec_unit;
    logic       dec_legal, dec_high, dec_rem, dec_signed;
    logic       can_accept, done_sel;
    logic [XLEN-1:0] unit_res;

    alu2_cmd_decode u_decode (
        .cmd       (bus.cmd),
        .unit      (dec_unit),
        .legal     (dec_legal),
        .sel_high  (dec_high),
        .sel_rem   (dec_rem),
        .is_signed (dec_signed)
    );

    // Only the selected unit's done counts; divider corrections follow RISC-V.
    always_comb begin
        done_sel = 1'b0;
        unit_res = '0;
        case (unit_reg)
            UNIT_MUL: begin
                done_sel = mul_done;
                unit_res = high_reg ? mul_high : mul_low;
            end
            UNIT_DIV: begin
                done_sel = div_done;
                if (div_by_zero)
                    unit_res = rem_reg ? op_a_reg : '1;
                else if (sgn_reg && op_a_reg == INT_MIN && op_b_reg == '1)
                    unit_res = rem_reg ? '0 : INT_MIN;
                else
                    unit_res = rem_reg ? div_remainder : div_quotient;
            end
            UNIT_SHIFT: begin
                done_sel = shift_done;
                unit_res = shift_result;
            end
            default: ;
        endcase
    end

    assign can_accept = (state_reg == IDLE) || (state_reg == HOLD && bus.clear);

    always_comb begin
        state_next = state_reg;
        op_a_next  = op_a_reg;
        op_b_next  = op_b_reg;
        cmd_q_next = cmd_q_reg;
        rd_next    = rd_reg;
        res_next   = res_reg;
        err_next   = err_reg;
        valid_next = valid_reg;
        ierr_next  = 1'b0;
        start_next = 3'b000;
        wd_next    = wd_reg;
        unit_next  = unit_reg;
        high_next  = high_reg;
        rem_next   = rem_reg;
        sgn_next   = sgn_reg;
        if (bus.flush) begin
            state_next = IDLE;
            valid_next = 1'b0;
            res_next   = '0;
            err_next   = 1'b0;
        end else begin
            case (state_reg)
                START: begin
                    state_next = WAIT;
                    wd_next    = '0;
                end
                WAIT: begin
                    if (done_sel) begin
                        res_next   = unit_res;
                        err_next   = 1'b0;
                        valid_next = 1'b1;
                        state_next = HOLD;
                    end else if (wd_reg == WD_W'(TIMEOUT - 1)) begin
                        res_next   = '0;
                        err_next   = 1'b1;
                        valid_next = 1'b1;
                        state_next = HOLD;
                    end else begin
                        wd_next = wd_reg + WD_W'(1);
                    end
                end
                HOLD: begin
                    if (bus.clear) begin
                        state_next = IDLE;
                        valid_next = 1'b0;
                        res_next   = '0;
                        err_next   = 1'b0;
                    end
                end
                default: ;
            endcase
            if (can_accept && bus.issue_valid) begin
                if (dec_legal) begin
                    state_next = START;
                    op_a_next  = bus.arg0;
                    op_b_next  = bus.arg1;
                    cmd_q_next = bus.cmd;
                    rd_next    = bus.i_rd;
                    unit_next  = dec_unit;
                    high_next  = dec_high;
                    rem_next   = dec_rem;
                    sgn_next   = dec_signed;
                    wd_next    = '0;
                    case (dec_unit)
                        UNIT_MUL:   start_next = 3'b001;
                        UNIT_DIV:   start_next = 3'b010;
                        UNIT_SHIFT: start_next = 3'b100;
                        default:    start_next = 3'b000;
                    endcase
                end else begin
                    ierr_next = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            op_a_reg  <= '0;
            op_b_reg  <= '0;
            cmd_q_reg <= ALU_ADD;
            rd_reg    <= '0;
            res_reg   <= '0;
            err_reg   <= 1'b0;
            valid_reg <= 1'b0;
            ierr_reg  <= 1'b0;
            start_reg <= 3'b000;
            wd_reg    <= '0;
            unit_reg  <= UNIT_NONE;
            high_reg  <= 1'b0;
            rem_reg   <= 1'b0;
            sgn_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            op_a_reg  <= op_a_next;
            op_b_reg  <= op_b_next;
            cmd_q_reg <= cmd_q_next;
            rd_reg    <= rd_next;
            res_reg   <= res_next;
            err_reg   <= err_next;
            valid_reg <= valid_next;
            ierr_reg  <= ierr_next;
            start_reg <= start_next;
            wd_reg    <= wd_next;
            unit_reg  <= unit_next;
            high_reg  <= high_next;
            rem_reg   <= rem_next;
            sgn_reg   <= sgn_next;
        end
    end

    assign bus.busy    = (state_reg != IDLE) && !(state_reg == HOLD && bus.clear);
    assign bus.i_error = ierr_reg;
    assign bus.res     = res_reg;
    assign bus.o_rd    = rd_reg;
    assign bus.valid   = valid_reg;
    assign bus.req     = valid_reg;
    assign bus.o_error = err_reg;
    assign op_a        = op_a_reg;
    assign op_b        = op_b_reg;
    assign cmd_q       = cmd_q_reg;
    assign mul_start   = start_reg[0];
    assign div_start   = start_reg[1];
    assign shift_start = start_reg[2];
endmodule

// File: tb/tb_alu2_sequencer.sv
// Randomized and directed bench for alu2_sequencer against an arithmetic reference model.
module tb_alu2_sequencer;
    import alu2_sequencer_pkg::*;

    localparam int TMO = ALU2_TIMEOUT;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    alu2_sequencer_if bus();

    logic [31:0]   op_a, op_b;
    alu_commands_t cmd_q;
    logic          mul_start, div_start, shift_start;
    logic          mul_done, div_done, shift_done;
    logic [31:0]   mul_low, mul_high, div_quotient, div_remainder, shift_result;
    logic          div_by_zero;

    alu2_sequencer #(.TIMEOUT(TMO)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .bus           (bus),
        .op_a          (op_a),
        .op_b          (op_b),
        .cmd_q         (cmd_q),
        .mul_start     (mul_start),
        .div_start     (div_start),
        .shift_start   (shift_start),
        .mul_done      (mul_done),
        .div_done      (div_done),
        .shift_done    (shift_done),
        .mul_low       (mul_low),
        .mul_high      (mul_high),
        .div_quotient  (div_quotient),
        .div_remainder (div_remainder),
        .shift_result  (shift_result),
        .div_by_zero   (div_by_zero)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [2:0] starts();
        return {shift_start, div_start, mul_start};
    endfunction

    // One-hot {shift, div, mul} of the unit that must run a command.
    function automatic logic [2:0] unit_of(input alu_commands_t c);
        case (c)
            ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU: return 3'b001;
            ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU:     return 3'b010;
            ALU_SLL, ALU_SRL, ALU_SRA:               return 3'b100;
            default:                                 return 3'b000;
        endcase
    endfunction

    // Architectural result of each command, straight from the RISC-V M/I rules.
    function automatic logic [31:0] ref_result(input alu_commands_t c, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, ub, p;
        logic [63:0] pu;
        logic ovf;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        ub  = longint'({32'b0, b});
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (c)
            ALU_MUL:    return a * b;
            ALU_MULH:   begin p = sa * sb; return p[63:32]; end
            ALU_MULHSU: begin p = sa * ub; return p[63:32]; end
            ALU_MULHU:  begin pu = {32'b0, a} * {32'b0, b}; return pu[63:32]; end
            ALU_DIV:    return (b == 0) ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000 : 32'(sa / sb);
            ALU_DIVU:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
            ALU_REM:    return (b == 0) ? a : ovf ? 32'h0 : 32'(sa % sb);
            ALU_REMU:   return (b == 0) ? a : a % b;
            ALU_SLL:    return a << b[4:0];
            ALU_SRL:    return a >> b[4:0];
            ALU_SRA:    return 32'($signed(a) >>> b[4:0]);
            default:    return 32'h0;
        endcase
    endfunction

    // Behavioural units: raw results, with garbage where the divider is undefined.
    task automatic drive_units(input alu_commands_t c, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, ub, p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ub = longint'({32'b0, b});
        mul_low       = $urandom;
        mul_high      = $urandom;
        div_quotient  = $urandom;
        div_remainder = $urandom;
        shift_result  = $urandom;
        div_by_zero   = 1'b0;
        case (unit_of(c))
            3'b001: begin
                if (c == ALU_MULH)        p = sa * sb;
                else if (c == ALU_MULHSU) p = sa * ub;
                else                      p = longint'({32'b0, a} * {32'b0, b});
                {mul_high, mul_low} = p;
            end
            3'b010: begin
                if (b == 0) begin
                    div_by_zero = 1'b1;
                end else if (c == ALU_DIV || c == ALU_REM) begin
                    if (!(a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) begin
                        div_quotient  = 32'(sa / sb);
                        div_remainder = 32'(sa % sb);
                    end
                end else begin
                    div_quotient  = a / b;
                    div_remainder = a % b;
                end
            end
            3'b100: shift_result = ref_result(c, a, b);
            default: ;
        endcase
    endtask

    task automatic issue(input alu_commands_t c, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
        bus.issue_valid = 1'b1;
        bus.cmd  = c;
        bus.arg0 = a;
        bus.arg1 = b;
        bus.i_rd = rd;
        #1;
        check("busy_at_issue", 64'(bus.busy), 64'd0);
        step();
        bus.issue_valid = 1'b0;
        bus.arg0 = $urandom;
        bus.arg1 = $urandom;
        bus.i_rd = 5'($urandom);
    endtask

    // Called in the START cycle; done arrives lat cycles after the start pulse.
    task automatic complete(input alu_commands_t c, input logic [31:0] a, input logic [31:0] b,
                            input logic [4:0] rd, input int lat, input bit noise);
        logic [2:0] sel, d;
        sel = unit_of(c);
        check("start_pulse", 64'(starts()), 64'(sel));
        check("busy_in_start", 64'(bus.busy), 64'd1);
        check("op_a", 64'(op_a), 64'(a));
        check("op_b", 64'(op_b), 64'(b));
        check("cmd_q", 64'(cmd_q), 64'(c));
        drive_units(c, a, b);
        for (int k = 1; k <= lat; k++) begin
            step();
            if (k == 1) check("start_one_cycle", 64'(starts()), 64'd0);
            if (k == lat) check("valid_early", 64'(bus.valid), 64'd0);
            d = noise ? (3'($urandom) & ~sel) : 3'b000;
            if (k == lat) d = d | sel;
            {shift_done, div_done, mul_done} = d;
        end
        step();
        {shift_done, div_done, mul_done} = 3'b000;
        check("valid", 64'(bus.valid), 64'd1);
        check("req", 64'(bus.req), 64'd1);
        check("res", 64'(bus.res), 64'(ref_result(c, a, b)));
        check("o_rd", 64'(bus.o_rd), 64'(rd));
        check("o_error", 64'(bus.o_error), 64'd0);
        $display("[%0t] %s a=%h b=%h rd=%0d lat=%0d -> res=%h", $time, c.name(), a, b, rd, lat, bus.res);
    endtask

    task automatic commit();
        bus.clear = 1'b1;
        #1;
        check("busy_on_clear", 64'(bus.busy), 64'd0);
        step();
        bus.clear = 1'b0;
        check("valid_after_clear", 64'(bus.valid), 64'd0);
        check("busy_after_clear", 64'(bus.busy), 64'd0);
    endtask

    task automatic run_op(input alu_commands_t c, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd, input int lat, input bit noise);
        issue(c, a, b, rd);
        complete(c, a, b, rd, lat, noise);
        commit();
    endtask

    task automatic illegal_issue(input alu_commands_t c);
        bus.issue_valid = 1'b1;
        bus.cmd  = c;
        bus.arg0 = $urandom;
        bus.arg1 = $urandom;
        #1;
        check("busy_illegal", 64'(bus.busy), 64'd0);
        step();
        bus.issue_valid = 1'b0;
        check("i_error_pulse", 64'(bus.i_error), 64'd1);
        check("no_start_illegal", 64'(starts()), 64'd0);
        check("busy_after_illegal", 64'(bus.busy), 64'd0);
        step();
        check("i_error_single", 64'(bus.i_error), 64'd0);
        check("no_start_later", 64'(starts()), 64'd0);
        $display("[%0t] illegal %s -> i_error pulse", $time, c.name());
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'h0;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'($urandom_range(0, 40));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        alu_commands_t c;
        int r;
        bus.issue_valid = 1'b0;
        bus.cmd   = ALU_ADD;
        bus.arg0  = '0;
        bus.arg1  = '0;
        bus.i_rd  = '0;
        bus.flush = 1'b0;
        bus.clear = 1'b0;
        {mul_done, div_done, shift_done} = 3'b000;
        mul_low = '0; mul_high = '0; div_quotient = '0; div_remainder = '0; shift_result = '0;
        div_by_zero = 1'b0;

        #12;
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_valid", 64'({bus.valid, bus.req, bus.o_error, bus.i_error}), 64'd0);
        check("rst_res", 64'(bus.res), 64'd0);
        check("rst_o_rd", 64'(bus.o_rd), 64'd0);
        check("rst_ops", {op_a, op_b}, 64'd0);
        check("rst_cmd_q", 64'(cmd_q), 64'd0);
        check("rst_starts", 64'(starts()), 64'd0);
        #1 rst_n = 1'b1;
        step();

        // MUL with done four cycles after start: valid six cycles after accept.
        run_op(ALU_MUL, 32'd7, 32'hFFFF_FFFD, 5'd13, 4, 1'b0);

        // MULHU, then clear coinciding with a new SRL issue.
        issue(ALU_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3);
        complete(ALU_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, 2, 1'b1);
        bus.clear = 1'b1;
        issue(ALU_SRL, 32'h8000_0000, 32'd4, 5'd7);
        bus.clear = 1'b0;
        complete(ALU_SRL, 32'h8000_0000, 32'd4, 5'd7, 3, 1'b1);
        commit();

        // Divider corrections.
        run_op(ALU_DIV, 32'd5, 32'd0, 5'd1, 2, 1'b1);
        run_op(ALU_REM, 32'd5, 32'd0, 5'd2, 3, 1'b1);
        run_op(ALU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd4, 1, 1'b1);
        run_op(ALU_REM, 32'h8000_0000, 32'hFFFF_FFFF, 5'd5, 5, 1'b1);

        illegal_issue(ALU_ADD);

        // Watchdog: divider never answers.
        issue(ALU_DIV, 32'd9, 32'd3, 5'd2);
        check("tmo_start", 64'(starts()), 64'b010);
        step();
        for (int k = 0; k < TMO; k++) begin
            if (k == TMO - 1) check("tmo_valid_early", 64'(bus.valid), 64'd0);
            mul_done = 1'b1;
            step();
            mul_done = 1'b0;
        end
        check("tmo_valid", 64'(bus.valid), 64'd1);
        check("tmo_o_error", 64'(bus.o_error), 64'd1);
        check("tmo_res", 64'(bus.res), 64'd0);
        $display("[%0t] DIV timeout -> o_error=%0b res=%h", $time, bus.o_error, bus.res);
        commit();
        check("tmo_o_error_cleared", 64'(bus.o_error), 64'd0);

        // Flush in WAIT, then a late done must be ignored.
        issue(ALU_MUL, 32'd3, 32'd4, 5'd9);
        drive_units(ALU_MUL, 32'd3, 32'd4);
        step();
        step();
        bus.flush = 1'b1;
        bus.clear = 1'b1;
        step();
        bus.flush = 1'b0;
        bus.clear = 1'b0;
        check("flush_busy", 64'(bus.busy), 64'd0);
        check("flush_valid", 64'(bus.valid), 64'd0);
        mul_done = 1'b1;
        step();
        mul_done = 1'b0;
        for (int k = 0; k < 3; k++) begin
            check("late_done_valid", 64'(bus.valid), 64'd0);
            step();
        end
        $display("[%0t] MUL flushed in WAIT, late done ignored", $time);
        run_op(ALU_SRA, 32'h8000_00F0, 32'd4, 5'd30, 2, 1'b1);

        // Asynchronous reset in the middle of WAIT.
        issue(ALU_DIVU, 32'd100, 32'd7, 5'd21);
        step();
        step();
        #2 rst_n = 1'b0;
        #1;
        check("arst_busy", 64'(bus.busy), 64'd0);
        check("arst_ops", {op_a, op_b}, 64'd0);
        check("arst_o_rd", 64'(bus.o_rd), 64'd0);
        check("arst_starts", 64'(starts()), 64'd0);
        check("arst_valid", 64'({bus.valid, bus.req, bus.o_error}), 64'd0);
        $display("[%0t] reset during WAIT -> outputs cleared", $time);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // Randomized traffic.
        for (int i = 0; i < 40; i++) begin
            r = $urandom_range(0, 11);
            if (r < 8)       c = alu_commands_t'(5'(10 + r));
            else if (r == 8) c = ALU_SLL;
            else if (r == 9) c = ALU_SRL;
            else if (r == 10) c = ALU_SRA;
            else             c = alu_commands_t'(5'($urandom_range(0, 9)));
            if (unit_of(c) == 3'b000 || r == 11) begin
                if (unit_of(c) == 3'b000) illegal_issue(c);
            end else begin
                run_op(c, pick(), pick(), 5'($urandom), $urandom_range(1, 6), 1'b1);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
